simmem_mem_responder: RTL and testbench

SIMMEM_MEM_RESPONDER -- requirements
Module: simmem_mem_responder

---
 rtl/simmem_mem_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_simmem_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_mem_responder.sv
// Simulated memory responder: registered request/response FIFOs,
// fixed-latency read bursts and write-beat counting against the address length.
module simmem_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Flags come from registered pointers, so a pop never frees a slot
    // for a push in the same cycle.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_i && !full_o) begin
            mem_d[wr_q[AW-1:0]] = data_i;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop_i && !empty_o) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

module simmem_mem_responder #(
    parameter int IdWidth       = 4,
    parameter int BurstLenWidth = 4,
    parameter int DataWidth     = 32,
    parameter int QueueDepth    = 4,
    parameter int ReadLatency   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     raddr_valid_i,
    output logic                     raddr_ready_o,
    input  logic [IdWidth-1:0]       raddr_id_i,
    input  logic [BurstLenWidth-1:0] raddr_burst_len_i,
    input  logic                     waddr_valid_i,
    output logic                     waddr_ready_o,
    input  logic [IdWidth-1:0]       waddr_id_i,
    input  logic [BurstLenWidth-1:0] waddr_burst_len_i,
    input  logic                     wdata_valid_i,
    output logic                     wdata_ready_o,
    input  logic                     wdata_last_i,
    output logic                     rdata_valid_o,
    input  logic                     rdata_ready_i,
    output logic [IdWidth-1:0]       rdata_id_o,
    output logic [DataWidth-1:0]     rdata_data_o,
    output logic                     rdata_last_o,
    output logic                     wresp_valid_o,
    input  logic                     wresp_ready_i,
    output logic [IdWidth-1:0]       wresp_id_o,
    output logic                     wlast_err_o
);
    localparam int AddrW = IdWidth + BurstLenWidth;
    localparam logic [7:0] DelayInit = 8'(ReadLatency);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } rstate_e;

    logic [AddrW-1:0]         raddr_head;
    logic                     raddr_empty, raddr_full;
    logic                     rd_pop;
    logic [AddrW-1:0]         waddr_head;
    logic                     waddr_empty, waddr_full;
    logic                     w_pop;
    logic [IdWidth-1:0]       wresp_head;
    logic                     wresp_empty, wresp_full;
    logic                     b_push;

    rstate_e                  state_q, state_d;
    logic [IdWidth-1:0]       rid_q, rid_d;
    logic [BurstLenWidth-1:0] rlen_q, rlen_d;
    logic [BurstLenWidth-1:0] beat_q, beat_d;
    logic [7:0]               delay_q, delay_d;
    logic [BurstLenWidth-1:0] wcnt_q, wcnt_d;
    logic                     werr_q, werr_d;

    logic [IdWidth-1:0]       whead_id;
    logic [BurstLenWidth-1:0] whead_len;
    logic                     wd_hs, wd_match;

    simmem_fifo #(.Width(AddrW), .Depth(QueueDepth)) u_raddr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (raddr_valid_i),
        .data_i  ({raddr_id_i, raddr_burst_len_i}),
        .pop_i   (rd_pop),
        .data_o  (raddr_head),
        .empty_o (raddr_empty),
        .full_o  (raddr_full)
    );

    simmem_fifo #(.Width(AddrW), .Depth(QueueDepth)) u_waddr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (waddr_valid_i),
        .data_i  ({waddr_id_i, waddr_burst_len_i}),
        .pop_i   (w_pop),
        .data_o  (waddr_head),
        .empty_o (waddr_empty),
        .full_o  (waddr_full)
    );

    simmem_fifo #(.Width(IdWidth), .Depth(QueueDepth)) u_wresp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (b_push),
        .data_i  (whead_id),
        .pop_i   (wresp_valid_o && wresp_ready_i),
        .data_o  (wresp_head),
        .empty_o (wresp_empty),
        .full_o  (wresp_full)
    );

    assign raddr_ready_o = !raddr_full;
    assign waddr_ready_o = !waddr_full;

    always_comb begin
        state_d       = state_q;
        rid_d         = rid_q;
        rlen_d        = rlen_q;
        beat_d        = beat_q;
        delay_d       = delay_q;
        rd_pop        = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_id_o    = '0;
        rdata_data_o  = '0;
        rdata_last_o  = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (!raddr_empty) begin
                    rd_pop          = 1'b1;
                    {rid_d, rlen_d} = raddr_head;
                    beat_d          = '0;
                    delay_d         = DelayInit;
                    state_d = (ReadLatency > 0) ? R_WAIT : R_BURST;
                end
            end
            R_WAIT: begin
                if (delay_q <= 8'd1) begin
                    state_d = R_BURST;
                end else begin
                    delay_d = delay_q - 8'd1;
                end
            end
            R_BURST: begin
                rdata_valid_o = 1'b1;
                rdata_id_o    = rid_q;
                rdata_data_o  = DataWidth'({rid_q, beat_q});
                rdata_last_o  = (beat_q == rlen_q);
                if (rdata_ready_i) begin
                    if (rdata_last_o) begin
                        state_d = R_IDLE;
                    end else begin
                        beat_d = beat_q + BurstLenWidth'(1);
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign {whead_id, whead_len} = waddr_head;
    assign wdata_ready_o = !waddr_empty && !wresp_full;
    assign wd_hs         = wdata_valid_i && wdata_ready_o;
    assign wd_match      = (wcnt_q == whead_len);

    // Burst boundaries follow the address length; wdata_last_i only
    // feeds the sticky mismatch flag.
    always_comb begin
        wcnt_d = wcnt_q;
        werr_d = werr_q;
        w_pop  = 1'b0;
        b_push = 1'b0;
        if (wd_hs) begin
            if (wdata_last_i != wd_match) begin
                werr_d = 1'b1;
            end
            if (wd_match) begin
                w_pop  = 1'b1;
                b_push = 1'b1;
                wcnt_d = '0;
            end else begin
                wcnt_d = wcnt_q + BurstLenWidth'(1);
            end
        end
    end

    assign wresp_valid_o = !wresp_empty;
    assign wresp_id_o    = wresp_valid_o ? wresp_head : '0;
    assign wlast_err_o   = werr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            rid_q   <= '0;
            rlen_q  <= '0;
            beat_q  <= '0;
            delay_q <= '0;
            wcnt_q  <= '0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rid_q   <= rid_d;
            rlen_q  <= rlen_d;
            beat_q  <= beat_d;
            delay_q <= delay_d;
            wcnt_q  <= wcnt_d;
            werr_q  <= werr_d;
        end
    end
endmodule

// File: tb/tb_simmem_mem_responder.sv
// Bench for simmem_mem_responder: directed scenarios plus a random
// phase checked against a queue-based transaction model.
module tb_simmem_mem_responder;
    localparam int QD = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        raddr_valid_i, raddr_ready_o;
    logic [3:0]  raddr_id_i, raddr_burst_len_i;
    logic        waddr_valid_i, waddr_ready_o;
    logic [3:0]  waddr_id_i, waddr_burst_len_i;
    logic        wdata_valid_i, wdata_ready_o, wdata_last_i;
    logic        rdata_valid_o, rdata_ready_i;
    logic [3:0]  rdata_id_o;
    logic [31:0] rdata_data_o;
    logic        rdata_last_o;
    logic        wresp_valid_o, wresp_ready_i;
    logic [3:0]  wresp_id_o;
    logic        wlast_err_o;

    simmem_mem_responder #(
        .IdWidth(4), .BurstLenWidth(4), .DataWidth(32),
        .QueueDepth(QD), .ReadLatency(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .raddr_valid_i(raddr_valid_i), .raddr_ready_o(raddr_ready_o),
        .raddr_id_i(raddr_id_i), .raddr_burst_len_i(raddr_burst_len_i),
        .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
        .waddr_id_i(waddr_id_i), .waddr_burst_len_i(waddr_burst_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_last_i(wdata_last_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
        .rdata_id_o(rdata_id_o), .rdata_data_o(rdata_data_o),
        .rdata_last_o(rdata_last_o),
        .wresp_valid_o(wresp_valid_o), .wresp_ready_i(wresp_ready_i),
        .wresp_id_o(wresp_id_o), .wlast_err_o(wlast_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t      rq[$];
    logic [3:0] wq_id[$];
    logic [3:0] wq_len[$];
    logic [3:0] bq[$];
    int         wcnt;
    logic       exp_err;
    logic       r_stall, b_stall;
    logic [31:0] r_hold;
    logic [3:0]  b_hold;
    int n_pass = 0, n_total = 0;
    int n_beats = 0, n_raddr = 0, n_wd = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare this cycle's outputs with the model, then absorb the
    // handshakes that the coming edge completes, then advance one cycle.
    task automatic tick();
        beat_t b;
        logic  islast;
        if (rst_i) begin
            rq.delete(); wq_id.delete(); wq_len.delete(); bq.delete();
            wcnt = 0; exp_err = 1'b0; r_stall = 1'b0; b_stall = 1'b0;
        end else begin
            if (r_stall) begin
                chk("r_hold_valid", rdata_valid_o, 1);
                chk("r_hold_data", rdata_data_o, r_hold);
            end
            if (b_stall) begin
                chk("b_hold_valid", wresp_valid_o, 1);
                chk("b_hold_id", wresp_id_o, b_hold);
            end
            chk("wlast_err", wlast_err_o, exp_err);
            chk("waddr_ready", waddr_ready_o, wq_id.size() < QD);
            chk("wdata_ready", wdata_ready_o,
                wq_id.size() != 0 && bq.size() < QD);
            if (rdata_valid_o) begin
                if (rq.size() == 0) begin
                    chk("r_spurious", rdata_valid_o, 0);
                end else begin
                    b = rq[0];
                    chk("r_id", rdata_id_o, b.id);
                    chk("r_data", rdata_data_o, b.data);
                    chk("r_last", rdata_last_o, b.last);
                    if (rdata_ready_i) begin
                        void'(rq.pop_front());
                        n_beats++;
                    end
                end
            end
            if (wresp_valid_o) begin
                if (bq.size() == 0) begin
                    chk("b_spurious", wresp_valid_o, 0);
                end else begin
                    chk("b_id", wresp_id_o, bq[0]);
                    if (wresp_ready_i) void'(bq.pop_front());
                end
            end
            if (raddr_valid_i && raddr_ready_o) begin
                for (int i = 0; i <= int'(raddr_burst_len_i); i++) begin
                    b.id   = raddr_id_i;
                    b.data = {24'h0, raddr_id_i, 4'(i)};
                    b.last = (i == int'(raddr_burst_len_i));
                    rq.push_back(b);
                end
                n_raddr++;
            end
            if (wdata_valid_i && wdata_ready_o && wq_id.size() != 0) begin
                islast = (wcnt == int'(wq_len[0]));
                if (wdata_last_i != islast) exp_err = 1'b1;
                if (islast) begin
                    bq.push_back(wq_id[0]);
                    void'(wq_id.pop_front());
                    void'(wq_len.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
                n_wd++;
            end
            if (waddr_valid_i && waddr_ready_o) begin
                wq_id.push_back(waddr_id_i);
                wq_len.push_back(waddr_burst_len_i);
            end
            r_stall = rdata_valid_o && !rdata_ready_i;
            r_hold  = rdata_data_o;
            b_stall = wresp_valid_o && !wresp_ready_i;
            b_hold  = wresp_id_o;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        raddr_valid_i = 0; raddr_id_i = 0; raddr_burst_len_i = 0;
        waddr_valid_i = 0; waddr_id_i = 0; waddr_burst_len_i = 0;
        wdata_valid_i = 0; wdata_last_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic send_wbeat(input logic last);
        int k = 0;
        wdata_valid_i = 1'b1;
        wdata_last_i  = last;
        while (!wdata_ready_o && k < 20) begin
            tick();
            k++;
        end
        chk("wbeat_ready", wdata_ready_o, 1);
        tick();
        wdata_valid_i = 1'b0;
        wdata_last_i  = 1'b0;
    endtask

    initial begin
        int lat, n0, k;
        idle_inputs();
        rdata_ready_i = 1'b1;
        wresp_ready_i = 1'b1;
        do_reset();

        chk("rst_raddr_ready", raddr_ready_o, 1);
        chk("rst_waddr_ready", waddr_ready_o, 1);
        chk("rst_wdata_ready", wdata_ready_o, 0);
        chk("rst_rvalid", rdata_valid_o, 0);
        chk("rst_bvalid", wresp_valid_o, 0);
        chk("rst_rid", rdata_id_o, 0);
        chk("rst_rdata", rdata_data_o, 0);
        chk("rst_rlast", rdata_last_o, 0);
        chk("rst_bid", wresp_id_o, 0);
        chk("rst_err", wlast_err_o, 0);

        // single beat, latency t+2+ReadLatency
        raddr_valid_i = 1; raddr_id_i = 3; raddr_burst_len_i = 0;
        tick();
        raddr_valid_i = 0;
        lat = 1;
        while (!rdata_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("rd_latency", lat, 4);
        chk("rd_single_data", rdata_data_o, 32'h30);
        chk("rd_single_last", rdata_last_o, 1);
        repeat (3) tick();

        // backpressured burst
        n0 = n_beats;
        raddr_valid_i = 1; raddr_id_i = 5; raddr_burst_len_i = 3;
        tick();
        raddr_valid_i = 0;
        for (int i = 0; i < 30; i++) begin
            rdata_ready_i = i[0];
            tick();
        end
        rdata_ready_i = 1;
        chk("bp_beats", n_beats - n0, 4);

        // write burst with correct last
        waddr_valid_i = 1; waddr_id_i = 2; waddr_burst_len_i = 1;
        tick();
        waddr_valid_i = 0;
        send_wbeat(0);
        send_wbeat(1);
        chk("wr_bvalid", wresp_valid_o, 1);
        chk("wr_bid", wresp_id_o, 2);
        repeat (3) tick();
        chk("wr_err_clear", wlast_err_o, 0);

        // wlast mismatch
        waddr_valid_i = 1; waddr_id_i = 6; waddr_burst_len_i = 2;
        tick();
        waddr_valid_i = 0;
        send_wbeat(1);
        chk("err_set", wlast_err_o, 1);
        send_wbeat(0);
        send_wbeat(1);
        chk("err_bvalid", wresp_valid_o, 1);
        chk("err_bid", wresp_id_o, 6);
        repeat (3) tick();
        chk("err_sticky", wlast_err_o, 1);
        do_reset();
        chk("err_rst", wlast_err_o, 0);

        // raddr FIFO full (FSM holds one request in its burst)
        rdata_ready_i = 0;
        n0 = n_raddr;
        raddr_valid_i = 1; raddr_id_i = 7; raddr_burst_len_i = 0;
        repeat (12) tick();
        chk("raddr_full_cnt", n_raddr - n0, QD + 1);
        chk("raddr_full_ready", raddr_ready_o, 0);
        raddr_valid_i = 0;
        rdata_ready_i = 1;
        repeat (40) tick();
        chk("raddr_drain", rq.size(), 0);

        // wresp FIFO full
        wresp_ready_i = 0;
        n0 = n_wd;
        waddr_valid_i = 1; waddr_id_i = 9; waddr_burst_len_i = 0;
        wdata_valid_i = 1; wdata_last_i = 1;
        repeat (20) tick();
        chk("wresp_full_wready", wdata_ready_o, 0);
        chk("wresp_full_cnt", n_wd - n0, QD);
        waddr_valid_i = 0;
        wresp_ready_i = 1;
        repeat (40) tick();
        wdata_valid_i = 0;
        tick();
        chk("wresp_drain", bq.size() + wq_id.size(), 0);

        // reset in the middle of a long burst
        raddr_valid_i = 1; raddr_id_i = 4'hA; raddr_burst_len_i = 7;
        tick();
        raddr_valid_i = 0;
        k = 0;
        while (!(rdata_valid_o && rdata_data_o[3:0] == 4'd2) && k < 20) begin
            tick();
            k++;
        end
        chk("mid_beat2_seen", rdata_data_o[3:0], 2);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("mid_abort", rdata_valid_o, 0);
        repeat (15) tick();
        n0 = n_beats;
        raddr_valid_i = 1; raddr_id_i = 4'hB; raddr_burst_len_i = 1;
        tick();
        raddr_valid_i = 0;
        repeat (15) tick();
        chk("mid_new_beats", n_beats - n0, 2);

        // random traffic on all five channels
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            raddr_valid_i = ($urandom_range(0, 3) == 0);
            raddr_id_i = 4'($urandom);
            raddr_burst_len_i = ($urandom_range(0, 7) == 0) ? 4'hF
                                : 4'($urandom_range(0, 3));
            waddr_valid_i = ($urandom_range(0, 2) == 0);
            waddr_id_i = 4'($urandom);
            waddr_burst_len_i = 4'($urandom_range(0, 3));
            wdata_valid_i = $urandom_range(0, 1) == 1;
            wdata_last_i = (wq_len.size() != 0) && (wcnt == int'(wq_len[0]));
            rdata_ready_i = $urandom_range(0, 1) == 1;
            wresp_ready_i = $urandom_range(0, 1) == 1;
            tick();
        end
        idle_inputs();
        rdata_ready_i = 1;
        wresp_ready_i = 1;
        repeat (200) tick();
        chk("rand_r_drain", rq.size(), 0);
        chk("rand_b_drain", bq.size(), 0);
        chk("rand_err", wlast_err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
